// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - MIPS HI/LO execute unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO
// Owns HI/LO, runs multiplies internally and sequences the external multicycle divider.
module muldiv_hilo_unit #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_valid,
  output logic        div_sig,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [63:0] div_c
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV_RUN, S_DIV_CAP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic        mul_sig_q, mul_sig_d;
  logic        first_q, first_d;
  logic        discard_q, discard_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        div_valid_q, div_valid_d;
  logic        div_sig_q, div_sig_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;

  logic [63:0] ext_a, ext_b, product;

  // Sign/zero extending to 64 bits makes the truncated 64x64 product exact for both flavours.
  always_comb begin
    ext_a   = mul_sig_q ? {{32{op_a_q[31]}}, op_a_q} : {32'b0, op_a_q};
    ext_b   = mul_sig_q ? {{32{op_b_q[31]}}, op_b_q} : {32'b0, op_b_q};
    product = ext_a * ext_b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mul_sig_d = mul_sig_q;
    first_d   = first_q;
    discard_d = discard_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_sig_d = div_sig_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            3'd0, 3'd1: begin
              op_a_d    = req_a;
              op_b_d    = req_b;
              mul_sig_d = (req_op == 3'd0);
              cnt_d     = CNT_INIT;
              state_d   = S_MUL;
            end
            3'd2, 3'd3: begin
              if (req_b != 32'd0) begin
                div_a_d   = req_a;
                div_b_d   = req_b;
                div_sig_d = (req_op == 3'd2);
                first_d   = 1'b1;
                discard_d = 1'b0;
                state_d   = S_DIV_RUN;
              end
            end
            3'd4:    hi_d = req_a;
            3'd5:    lo_d = req_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          {hi_d, lo_d} = product;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DIV_RUN: begin
        // done is high while the divider idles, so the entry cycle's done is stale
        first_d = 1'b0;
        if (kill) discard_d = 1'b1;
        if (!first_q && div_done) state_d = S_DIV_CAP;
      end
      S_DIV_CAP: begin
        if (!discard_q && !kill) begin
          lo_d = div_c[31:0];
          hi_d = div_c[63:32];
        end
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    div_valid_d = (state_d == S_DIV_RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      mul_sig_q   <= 1'b0;
      first_q     <= 1'b0;
      discard_q   <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      busy_q      <= 1'b0;
      div_valid_q <= 1'b0;
      div_sig_q   <= 1'b0;
      div_a_q     <= 32'd0;
      div_b_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      mul_sig_q   <= mul_sig_d;
      first_q     <= first_d;
      discard_q   <= discard_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      div_valid_q <= div_valid_d;
      div_sig_q   <= div_sig_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_valid = div_valid_q;
  assign div_sig   = div_sig_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;

endmodule
